spi_reg_bank: RTL and testbench

- SPI peripheral (mode 0, write-centric) that receives 16-bit frames from an off-chip controller and updates the design's control register bank.
- Sits directly upstream of the PWM/output stage inside the top-level user project; its register outputs drive output enables, PWM enables and the PWM duty cycle.
- SPI pins are asynchronous to clk; all sampling is done in the clk domain after synchronisers.

---
 rtl/spi_reg_bank.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: mode-0 SPI slave receiving 16-bit write frames
// ({rw, addr[6:0], data[7:0]}, MSB first) into a five-entry control
// register bank that feeds the PWM/output stage.
// Optional feature: define SPI_READBACK_EN to enable register readback on cipo.
module spi_reg_bank #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam int NUM_REGS = 5;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic                   sclk_prev_q, ncs_prev_q;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
   logic [4:0]             cnt_q, cnt_d;
   logic [15:0]            shreg_q, shreg_d;
   logic                   inv_q, inv_d;
   logic [7:0]             reg_q [NUM_REGS];
   logic [7:0]             reg_d [NUM_REGS];
   logic                   commit_s;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   assign sclk_rise_s = sclk_s & ~sclk_prev_q;
   assign sclk_fall_s = ~sclk_s & sclk_prev_q;
   assign ncs_rise_s  = ncs_s & ~ncs_prev_q;
   assign ncs_fall_s  = ~ncs_s & ncs_prev_q;

   // Next-state of the synchroniser chains: pin enters at bit 0, output at MSB.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
   end

   // Frame assembly: clear on ncs fall, shift on sclk rise, flag overlong frames.
   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      inv_d   = inv_q;
      if (ncs_fall_s) begin
         cnt_d   = 5'd0;
         shreg_d = 16'h0000;
         inv_d   = 1'b0;
      end else if (sclk_rise_s && !ncs_s) begin
         shreg_d = {shreg_q[14:0], copi_s};
         if (cnt_q == 5'd16) begin
            inv_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 5'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Only a complete, clean 16-bit write to a valid address is committed.
   assign commit_s = ncs_rise_s && (cnt_q == 5'd16) && !inv_q && shreg_q[15]
                     && (shreg_q[14:8] <= 7'(MAX_ADDR));

   // Register bank update on commit.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (commit_s && (shreg_q[14:8] == 7'(i))) begin
            reg_d[i] = shreg_q[7:0];
         end else begin
            reg_d[i] = reg_q[i];
         end
      end
   end

   // State flops for synchronisers, edge detectors, frame and register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '1;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
         cnt_q       <= 5'd0;
         shreg_q     <= 16'h0000;
         inv_q       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i] <= 8'h00;
         end
      end else begin
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         sclk_prev_q <= sclk_s;
         ncs_prev_q  <= ncs_s;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         inv_q       <= inv_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i] <= reg_d[i];
         end
      end
   end

   assign en_reg_out_7_0  = reg_q[0];
   assign en_reg_out_15_8 = reg_q[1];
   assign en_reg_pwm_7_0  = reg_q[2];
   assign en_reg_pwm_15_8 = reg_q[3];
   assign pwm_duty_cycle  = reg_q[4];

`ifdef SPI_READBACK_EN
   logic [7:0] out_q, out_d;
   logic       rd_act_q, rd_act_d;
   logic       cipo_q, cipo_d;
   logic [6:0] rd_addr_s;

   // Header byte as it stands once the 8th bit is shifted in.
   assign rd_addr_s = {shreg_q[5:0], copi_s};

   // Readback shifter: load at bit 8 of a read frame, shift on falls after bit 9.
   always_comb begin
      out_d    = out_q;
      rd_act_d = rd_act_q;
      if (ncs_fall_s || ncs_rise_s) begin
         out_d    = 8'h00;
         rd_act_d = 1'b0;
      end else if (sclk_rise_s && !ncs_s && (cnt_q == 5'd7)) begin
         rd_act_d = ~shreg_q[6];
         out_d    = 8'h00;
         for (int i = 0; i < NUM_REGS; i++) begin
            if ((rd_addr_s == 7'(i)) && (rd_addr_s <= 7'(MAX_ADDR))) begin
               out_d = reg_q[i];
            end else begin
               out_d = out_d;
            end
         end
      end else if (sclk_fall_s && !ncs_s && rd_act_q && (cnt_q >= 5'd9)) begin
         out_d = {out_q[6:0], 1'b0};
      end else begin
         out_d = out_q;
      end
      cipo_d = (rd_act_d && !ncs_s) ? out_d[7] : 1'b0;
   end

   // Readback state flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= 8'h00;
         rd_act_q <= 1'b0;
         cipo_q   <= 1'b0;
      end else begin
         out_q    <= out_d;
         rd_act_q <= rd_act_d;
         cipo_q   <= cipo_d;
      end
   end

   assign cipo = cipo_q;
`else
   assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank with a frame-level register model.
module tb_spi_reg_bank;

   localparam int SYNC = 2;
   localparam int MAXA = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic ncs = 1'b1;
   wire  cipo;
   wire [7:0] r0, r1, r2, r3, r4;
   wire [7:0] obs [5];

   int checks = 0;
   int errors = 0;
   logic [7:0] model [5];
   logic [31:0] cap;
   int cipo_hi = 0;

   spi_reg_bank #(.SYNC_STAGES(SYNC), .MAX_ADDR(MAXA)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
      .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
      .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4)
   );

   assign obs[0] = r0;
   assign obs[1] = r1;
   assign obs[2] = r2;
   assign obs[3] = r3;
   assign obs[4] = r4;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cipo !== 1'b0) cipo_hi = cipo_hi + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi = v[i];
         wait_clk(4);
         cap = {cap[30:0], cipo};
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   // Reference: only a full 16-bit write to an in-range address lands.
   task automatic model_apply(input logic [31:0] v, input int n);
      if (n == 16 && v[15] == 1'b1 && int'(v[14:8]) <= MAXA)
         model[int'(v[14:8])] = v[7:0];
   endtask

   task automatic frame(input logic [31:0] v, input int n, input int gap);
      ncs = 1'b0;
      wait_clk(4);
      cap = 32'h0;
      shift_bits(v, n);
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(gap);
      model_apply(v, n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      wait_clk(3);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs[i] !== 8'h00) begin
            errors++;
            $display("FAIL reset_reg%0d got %h want 00", i, obs[i]);
         end
      end
      checks++;
      if (cipo !== 1'b0) begin
         errors++;
         $display("FAIL reset_cipo got %b want 0", cipo);
      end
      rst_n = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_write;
      frame(32'h80F0, 16, SYNC + 2);
      frame(32'h8455, 16, SYNC + 2);
      checks++;
      if (obs[0] !== 8'hF0) begin
         errors++;
         $display("FAIL write_reg0 got %h want f0", obs[0]);
      end
      checks++;
      if (obs[4] !== 8'h55) begin
         errors++;
         $display("FAIL write_reg4 got %h want 55", obs[4]);
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (obs[i] !== model[i]) begin
            errors++;
            $display("FAIL write_other%0d got %h want %h", i, obs[i], model[i]);
         end
      end
   endtask

   task automatic test_discard;
      frame(32'h8AAB, 16, SYNC + 2);
      frame(32'h0233, 16, SYNC + 2);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs[i] !== model[i]) begin
            errors++;
            $display("FAIL discard_reg%0d got %h want %h", i, obs[i], model[i]);
         end
      end
   endtask

   task automatic test_aborted;
      frame(32'h082F, 12, SYNC + 2);
      frame({12'h0, 16'h82FF, 4'h5}, 20, SYNC + 2);
      checks++;
      if (obs[2] !== 8'h00) begin
         errors++;
         $display("FAIL aborted_reg2 got %h want 00", obs[2]);
      end
      frame(32'h82C3, 16, SYNC + 2);
      checks++;
      if (obs[2] !== 8'hC3) begin
         errors++;
         $display("FAIL aborted_follow got %h want c3", obs[2]);
      end
   endtask

   task automatic test_back_to_back;
      frame(32'h8101, 16, 8);
      frame(32'h8302, 16, 8);
      checks++;
      if (obs[1] !== 8'h01) begin
         errors++;
         $display("FAIL b2b_reg1 got %h want 01", obs[1]);
      end
      checks++;
      if (obs[3] !== 8'h02) begin
         errors++;
         $display("FAIL b2b_reg3 got %h want 02", obs[3]);
      end
   endtask

   task automatic test_random;
      logic [31:0] v;
      int n, sel;
      for (int k = 0; k < 24; k++) begin
         sel = int'($urandom_range(0, 5));
         n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
         v = $urandom;
         v[14:8] = 7'($urandom_range(0, 7));
         v[15] = ($urandom_range(0, 3) != 0);
         if (n == 15) v = v >> 1;
         frame(v, n, SYNC + 2);
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== model[i]) begin
               errors++;
               $display("FAIL rand%0d_reg%0d frame %h n %0d got %h want %h",
                        k, i, v, n, obs[i], model[i]);
            end
         end
      end
   endtask

   task automatic test_mid_reset;
      ncs = 1'b0;
      wait_clk(4);
      shift_bits(32'h0081, 8);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs[i] !== 8'h00) begin
            errors++;
            $display("FAIL midreset_reg%0d got %h want 00", i, obs[i]);
         end
      end
      ncs = 1'b1;
      sclk = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
      frame(32'h8177, 16, SYNC + 2);
      checks++;
      if (obs[1] !== 8'h77) begin
         errors++;
         $display("FAIL after_reset_reg1 got %h want 77", obs[1]);
      end
   endtask

`ifdef SPI_READBACK_EN
   task automatic test_readback;
      frame(32'h845A, 16, SYNC + 2);
      frame(32'h04C3, 16, SYNC + 2);
      checks++;
      if (cap[7:0] !== model[4] || cap[7:0] !== 8'h5A) begin
         errors++;
         $display("FAIL readback got %h want 5a", cap[7:0]);
      end
      checks++;
      if (obs[4] !== 8'h5A) begin
         errors++;
         $display("FAIL readback_nomod got %h want 5a", obs[4]);
      end
   endtask
`else
   task automatic test_cipo_idle;
      checks++;
      if (cipo_hi !== 0) begin
         errors++;
         $display("FAIL cipo_idle got %0d nonzero samples want 0", cipo_hi);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_discard();
      test_aborted();
      test_back_to_back();
      test_random();
      test_mid_reset();
`ifdef SPI_READBACK_EN
      test_readback();
`else
      test_cipo_idle();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
